man_align_pipe: RTL and testbench
=================================

# man_align_pipe

Two-stage pipelined mantissa alignment stage of the floating-point adder/subtractor, directly downstream of the exponent compare/swap stage. It takes the swapped exponents, the a<b compare flag, both operand mantissas (hidden bit included) and both signs. It selects the mantissas by the compare flag and computes the exponent difference. It then right-shifts the smaller-exponent mantissa into a guard/round/sticky-extended field for the mantissa add/sub stage. Valid/ready handshake on both sides; stalls propagate without data loss.

## Interface
Parameters:
- SIZE_EXP, 8, exponent width
- SIZE_MAN, 23, stored fraction width; internal mantissa = SIZE_MAN+1, aligned = SIZE_MAN+4 (G, R, S appended)

Ports:
- i_clk  input  1  clock; all state on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_valid  input  1  upstream transaction present
- o_ready  output  1  stage can accept this cycle
- i_compare  input  1  exponent a < exponent b (from swap stage)
- i_exp_less, i_exp_greater  input  SIZE_EXP  swapped exponents
- i_man_a, i_man_b  input  SIZE_MAN+1  mantissas with hidden bit
- i_sign_a, i_sign_b  input  1  operand signs
- o_valid  output  1  aligned result present
- i_ready  input  1  downstream accepts
- o_exp  output  SIZE_EXP  result exponent (= greater exponent)
- o_man_greater  output  SIZE_MAN+4  greater-exponent mantissa << 3, GRS = 000
- o_man_aligned  output  SIZE_MAN+4  smaller-exponent mantissa, shifted, GRS filled
- o_sign_greater, o_sign_less  output  1  signs routed with their mantissas

## Operation
- Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready.
- Stage 1 (register S1): i_compare=1 -> greater = b (man_b, sign_b), less = a; i_compare=0 (incl. equal exponents) -> greater = a, less = b. diff = i_exp_greater - i_exp_less, unsigned SIZE_EXP bits; upstream guarantees greater >= less.
- Stage 2 (register S2): ext = {man_less, 3'b000}; diff >= SIZE_MAN+4 -> aligned = {0…0, |man_less}; else aligned = ext >> diff, LSB |= OR of all ext bits shifted out. diff = 0 -> aligned = ext.
- No mantissa magnitude comparison, no effective-op decision, no special-value (NaN/Inf/zero) handling here; they are handled downstream.
- Per-stage advance: s2_en = !s2_valid | i_ready; s1_en = !s1_valid | s2_en; o_ready = s1_en. Bubbles collapse; throughput 1/cycle when i_ready=1.
- Held stage: registers and outputs stable while o_valid & !i_ready.

## Timing
- Latency 2 cycles from accepted input to o_valid with an unstalled pipeline.
- o_ready is combinational from i_ready and the valid flags; no combinational path from i_valid to o_ready.
- Reset (any time, including mid-stall): s1_valid = s2_valid = 0 immediately; o_valid = 0, o_exp = 0, o_man_greater = 0, o_man_aligned = 0, o_sign_greater = o_sign_less = 0; o_ready = 1 after release. In-flight transactions are discarded.
- Simultaneous output transfer and input transfer on a full pipe: both stages advance in the same cycle; no drop, no duplicate.
- Data registers load only on their stage enable with valid input; payload under valid=0 is don't-care but driven deterministically.

## Structure
- Shared package fp_add_pkg: SIZE_EXP, SIZE_MAN, GRS_BITS=3, derived widths, typedef struct s1_payload_t {exp, diff, man_greater, man_less, sign_greater, sign_less}.
- One sub-module MAN_shift_sticky: combinational right shifter, SIZE_MAN+4 in/out, SIZE_EXP shift amount, saturating with sticky OR. Instantiated in stage 2; separately testable.

## Test plan
- Basic: exp_greater=0x80, exp_less=0x7E, compare=0, man_a=0xC00000, man_b=0x800000 -> 2 cycles later o_exp=0x80, o_man_greater=0x6000000, o_man_aligned=0x1000000.
- Sticky: diff=4, man_less=0x800001 -> o_man_aligned=0x0400001 (S=1).
- Saturation: diff=30, man_less=0x800000 -> o_man_aligned=0x0000001; diff=0 -> aligned = man_less<<3.
- Swap: compare=1, man_a=0x800000 sign_a=1, man_b=0xFFFFFF sign_b=0 -> o_man_greater=0x7FFFFF8, o_sign_greater=0, o_sign_less=1.
- Back-pressure: stream 4 back-to-back, hold i_ready=0 for 3 cycles after first o_valid -> o_ready=0 once two are held, outputs stable, all 4 emerge in order, none lost or repeated.
- Reset mid-op: drop i_rst_n while o_valid=1 and stalled -> o_valid and all data outputs 0 asynchronously; after release o_ready=1 and the next transaction has 2-cycle latency.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared widths and the stage-1 payload type for the floating-point adder datapath.
package fp_add_pkg;

    localparam int SIZE_EXP = 8;
    localparam int SIZE_MAN = 23;
    localparam int GRS_BITS = 3;
    localparam int MAN_W    = SIZE_MAN + 1;
    localparam int ALIGN_W  = MAN_W + GRS_BITS;

    typedef struct packed {
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_EXP-1:0] diff;
        logic [MAN_W-1:0]    man_greater;
        logic [MAN_W-1:0]    man_less;
        logic                sign_greater;
        logic                sign_less;
    } s1_payload_t;

endpackage

// File: rtl/MAN_shift_sticky.sv
// Combinational right shifter that folds every bit shifted out into the result LSB
// (sticky), saturating to {0..0, |man_i} once the shift covers the whole field.
module MAN_shift_sticky #(
    parameter int WIDTH   = 27,
    parameter int SHAMT_W = 8
) (
    input  logic [WIDTH-1:0]   man_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   man_o
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lost_mask;
    logic             sticky;

    always_comb begin
        lost_mask = ~({WIDTH{1'b1}} << shamt_i);
        shifted   = man_i >> shamt_i;
        sticky    = |(man_i & lost_mask);
        if (int'(shamt_i) >= WIDTH) begin
            man_o = {{(WIDTH-1){1'b0}}, |man_i};
        end else begin
            man_o = {shifted[WIDTH-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/man_align_pipe.sv
// Two-stage mantissa alignment: stage 1 routes operands by the compare flag and forms
// the exponent difference, stage 2 shifts the smaller mantissa into a GRS-extended field.
module man_align_pipe #(
    parameter int SIZE_EXP = fp_add_pkg::SIZE_EXP,
    parameter int SIZE_MAN = fp_add_pkg::SIZE_MAN
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_compare,
    input  logic [SIZE_EXP-1:0] i_exp_less,
    input  logic [SIZE_EXP-1:0] i_exp_greater,
    input  logic [SIZE_MAN:0]   i_man_a,
    input  logic [SIZE_MAN:0]   i_man_b,
    input  logic                i_sign_a,
    input  logic                i_sign_b,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic [SIZE_MAN+3:0] o_man_greater,
    output logic [SIZE_MAN+3:0] o_man_aligned,
    output logic                o_sign_greater,
    output logic                o_sign_less
);

    import fp_add_pkg::*;

    localparam int AW = SIZE_MAN + 1 + GRS_BITS;

    s1_payload_t       s1_q, s1_d;
    logic              s1_valid_q;
    logic              s2_valid_q;
    logic [SIZE_EXP-1:0] s2_exp_q;
    logic [AW-1:0]     s2_man_greater_q, s2_man_greater_d;
    logic [AW-1:0]     s2_man_aligned_q, s2_man_aligned_d;
    logic              s2_sign_greater_q;
    logic              s2_sign_less_q;
    logic              s1_en, s2_en;

    // Each stage advances when it is empty or the stage after it is moving.
    assign s2_en   = !s2_valid_q || i_ready;
    assign s1_en   = !s1_valid_q || s2_en;
    assign o_ready = s1_en;

    always_comb begin
        s1_d      = '0;
        s1_d.exp  = i_exp_greater;
        s1_d.diff = i_exp_greater - i_exp_less;
        if (i_compare) begin
            s1_d.man_greater  = i_man_b;
            s1_d.sign_greater = i_sign_b;
            s1_d.man_less     = i_man_a;
            s1_d.sign_less    = i_sign_a;
        end else begin
            s1_d.man_greater  = i_man_a;
            s1_d.sign_greater = i_sign_a;
            s1_d.man_less     = i_man_b;
            s1_d.sign_less    = i_sign_b;
        end
    end

    assign s2_man_greater_d = {s1_q.man_greater, {GRS_BITS{1'b0}}};

    MAN_shift_sticky #(
        .WIDTH   (AW),
        .SHAMT_W (SIZE_EXP)
    ) u_shift (
        .man_i   ({s1_q.man_less, {GRS_BITS{1'b0}}}),
        .shamt_i (s1_q.diff),
        .man_o   (s2_man_aligned_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_en) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q        <= 1'b0;
            s2_exp_q          <= '0;
            s2_man_greater_q  <= '0;
            s2_man_aligned_q  <= '0;
            s2_sign_greater_q <= 1'b0;
            s2_sign_less_q    <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_q          <= s1_q.exp;
                s2_man_greater_q  <= s2_man_greater_d;
                s2_man_aligned_q  <= s2_man_aligned_d;
                s2_sign_greater_q <= s1_q.sign_greater;
                s2_sign_less_q    <= s1_q.sign_less;
            end
        end
    end

    assign o_valid        = s2_valid_q;
    assign o_exp          = s2_exp_q;
    assign o_man_greater  = s2_man_greater_q;
    assign o_man_aligned  = s2_man_aligned_q;
    assign o_sign_greater = s2_sign_greater_q;
    assign o_sign_less    = s2_sign_less_q;

endmodule

// File: tb/tb_man_align_pipe.sv
// Bench for man_align_pipe: directed vector table, back-pressure and reset sequences,
// and a randomized handshake stream checked against an arithmetic reference model.
module tb_man_align_pipe;

    localparam int EW = 8;
    localparam int MW = 24;
    localparam int AW = 27;
    localparam int PW = EW + 2 * AW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid, i_ready, i_compare, i_sign_a, i_sign_b;
    logic [EW-1:0] i_exp_less, i_exp_greater;
    logic [MW-1:0] i_man_a, i_man_b;
    logic          o_ready, o_valid, o_sign_greater, o_sign_less;
    logic [EW-1:0] o_exp;
    logic [AW-1:0] o_man_greater, o_man_aligned;
    logic [PW-1:0] out_word;

    always #5 clk = ~clk;

    man_align_pipe dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_compare      (i_compare),
        .i_exp_less     (i_exp_less),
        .i_exp_greater  (i_exp_greater),
        .i_man_a        (i_man_a),
        .i_man_b        (i_man_b),
        .i_sign_a       (i_sign_a),
        .i_sign_b       (i_sign_b),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_exp          (o_exp),
        .o_man_greater  (o_man_greater),
        .o_man_aligned  (o_man_aligned),
        .o_sign_greater (o_sign_greater),
        .o_sign_less    (o_sign_less)
    );

    assign out_word = {o_exp, o_man_greater, o_man_aligned, o_sign_greater, o_sign_less};

    typedef struct {
        logic          cmp;
        logic [EW-1:0] eg;
        logic [EW-1:0] el;
        logic [MW-1:0] ma;
        logic [MW-1:0] mb;
        logic          sa;
        logic          sb;
    } tx_t;

    typedef struct {
        tx_t           tx;
        logic [PW-1:0] exp;
    } vec_t;

    logic [PW-1:0] exp_q[$];
    tx_t           pend_q[$];
    vec_t          vecs[11];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_out = 0;

    function automatic logic [PW-1:0] pack(input logic [EW-1:0] e, input logic [AW-1:0] mg,
                                           input logic [AW-1:0] al, input logic sg, input logic sl);
        return {e, mg, al, sg, sl};
    endfunction

    function automatic tx_t mk(input logic cmp, input logic [EW-1:0] eg, input logic [EW-1:0] el,
                               input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                               input logic sa, input logic sb);
        tx_t t;
        t.cmp = cmp; t.eg = eg; t.el = el; t.ma = ma; t.mb = mb; t.sa = sa; t.sb = sb;
        return t;
    endfunction

    // Reference: pick operands, then divide the x8 mantissa by 2^diff, any remainder sets the LSB.
    function automatic logic [PW-1:0] model(input tx_t t);
        longint unsigned mg, ml, ext, al, div;
        logic            sg, sl;
        int              d;
        if (t.cmp) begin
            mg = longint'(t.mb); sg = t.sb; ml = longint'(t.ma); sl = t.sa;
        end else begin
            mg = longint'(t.ma); sg = t.sa; ml = longint'(t.mb); sl = t.sb;
        end
        d   = int'(t.eg) - int'(t.el);
        ext = ml * 8;
        if (d >= AW) begin
            al = (ml != 0) ? 1 : 0;
        end else begin
            div = longint'(1) << d;
            al  = ext / div;
            if ((ext % div) != 0) al = al | 1;
        end
        return pack(t.eg, AW'(mg * 8), AW'(al), sg, sl);
    endfunction

    function automatic tx_t rand_tx();
        tx_t t;
        int  maxd, d;
        t.el = EW'($urandom_range(0, 255));
        maxd = 255 - int'(t.el);
        if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, maxd));
        else d = int'($urandom_range(0, (maxd < 30) ? maxd : 30));
        t.eg  = EW'(int'(t.el) + d);
        t.cmp = 1'($urandom);
        t.ma  = ($urandom_range(0, 7) == 0) ? MW'($urandom) : {1'b1, 23'($urandom)};
        t.mb  = ($urandom_range(0, 7) == 0) ? MW'($urandom) : {1'b1, 23'($urandom)};
        t.sa  = 1'($urandom);
        t.sb  = 1'($urandom);
        return t;
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input tx_t t);
        i_compare = t.cmp; i_exp_greater = t.eg; i_exp_less = t.el;
        i_man_a = t.ma; i_man_b = t.mb; i_sign_a = t.sa; i_sign_b = t.sb;
    endtask

    // Called at a falling edge: drive, then score the transfers the next rising edge will make.
    task automatic tick(input logic v, input logic r, input tx_t t, output logic acc);
        i_valid = v;
        i_ready = r;
        apply(t);
        #1;
        if (o_valid && i_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got %h with nothing outstanding", out_word);
            end else begin
                check("stream_data", out_word, exp_q.pop_front());
            end
        end
        acc = i_valid && o_ready;
        if (acc) exp_q.push_back(model(t));
    endtask

    // Single transaction through an empty pipe with the output always ready.
    task automatic run_vec(input vec_t vv);
        apply(vv.tx);
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1 check("vec_ready", PW'(o_ready), PW'(1));
        @(negedge clk);
        i_valid = 1'b0;
        #1 check("vec_lat1", PW'(o_valid), PW'(0));
        @(negedge clk);
        #1 check("vec_lat2", PW'(o_valid), PW'(1));
        check("vec_data", out_word, vv.exp);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_t           t, zero_tx;
        logic          acc, v, r;
        logic [PW-1:0] snap;
        int            cyc, stall, out0;
        logic          started;

        zero_tx = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = '{mk(0, 8'h80, 8'h7E, 24'hC00000, 24'h800000, 0, 1), pack(8'h80, 27'h6000000, 27'h1000000, 0, 1)};
        vecs[1]  = '{mk(0, 8'h84, 8'h80, 24'h800000, 24'h800001, 1, 0), pack(8'h84, 27'h4000000, 27'h0400001, 1, 0)};
        vecs[2]  = '{mk(0, 8'h9E, 8'h80, 24'h800000, 24'h800000, 0, 0), pack(8'h9E, 27'h4000000, 27'h0000001, 0, 0)};
        vecs[3]  = '{mk(0, 8'h7F, 8'h7F, 24'hA00000, 24'h900001, 0, 0), pack(8'h7F, 27'h5000000, 27'h4800008, 0, 0)};
        vecs[4]  = '{mk(1, 8'h81, 8'h80, 24'h800000, 24'hFFFFFF, 1, 0), pack(8'h81, 27'h7FFFFF8, 27'h2000000, 0, 1)};
        vecs[5]  = '{mk(0, 8'h9B, 8'h80, 24'h800000, 24'hFFFFFF, 0, 0), pack(8'h9B, 27'h4000000, 27'h0000001, 0, 0)};
        vecs[6]  = '{mk(0, 8'h98, 8'h80, 24'h800000, 24'hC00000, 0, 0), pack(8'h98, 27'h4000000, 27'h0000006, 0, 0)};
        vecs[7]  = '{mk(0, 8'hFF, 8'h00, 24'h800000, 24'h000001, 0, 1), pack(8'hFF, 27'h4000000, 27'h0000001, 0, 1)};
        vecs[8]  = '{mk(1, 8'hFF, 8'h00, 24'h000000, 24'h800000, 0, 1), pack(8'hFF, 27'h4000000, 27'h0000000, 1, 0)};
        vecs[9]  = '{mk(0, 8'h83, 8'h80, 24'hFFFFFF, 24'h800007, 1, 1), pack(8'h83, 27'h7FFFFF8, 27'h0800007, 1, 1)};
        vecs[10] = '{mk(0, 8'h85, 8'h80, 24'h800000, 24'h800011, 0, 0), pack(8'h85, 27'h4000000, 27'h0200005, 0, 0)};

        // Reset state
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        apply(zero_tx);
        repeat (3) @(negedge clk);
        check("rst_valid", PW'(o_valid), PW'(0));
        check("rst_data", out_word, PW'(0));
        rst_n = 1'b1;
        #1 check("rst_ready", PW'(o_ready), PW'(1));
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Unstalled stream: input accepted every cycle
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, rand_tx(), acc);
            check("thru_accept", PW'(acc), PW'(1));
            @(negedge clk);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            tick(1'b0, 1'b1, zero_tx, acc);
            @(negedge clk);
            cyc++;
        end

        // Back-pressure: 4 back-to-back, output held 3 cycles after the first o_valid
        for (int i = 0; i < 4; i++) pend_q.push_back(rand_tx());
        started = 1'b0;
        stall = 0;
        snap = '0;
        cyc = 0;
        out0 = n_out;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 40) begin
            if (o_valid && !started) begin
                started = 1'b1;
                stall = 3;
                snap = out_word;
            end
            r = (stall == 0);
            v = (pend_q.size() > 0);
            t = v ? pend_q[0] : zero_tx;
            tick(v, r, t, acc);
            if (stall > 0) begin
                check("bp_ready_low", PW'(o_ready), PW'(0));
                check("bp_valid_held", PW'(o_valid), PW'(1));
                check("bp_hold", out_word, snap);
                stall--;
            end
            if (acc) void'(pend_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        check("bp_count", PW'(n_out - out0), PW'(4));
        pend_q.delete();

        // Reset while stalled with o_valid high
        tick(1'b1, 1'b0, vecs[4].tx, acc);
        @(negedge clk);
        tick(1'b1, 1'b0, vecs[5].tx, acc);
        @(negedge clk);
        i_valid = 1'b0;
        #1 check("mid_valid_before", PW'(o_valid), PW'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", PW'(o_valid), PW'(0));
        check("mid_rst_data", out_word, PW'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst_ready", PW'(o_ready), PW'(1));
        run_vec(vecs[1]);

        // Randomized handshake stream against the reference model
        for (int i = 0; i < 400; i++) pend_q.push_back(rand_tx());
        cyc = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
            v = (pend_q.size() > 0) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            t = (pend_q.size() > 0) ? pend_q[0] : zero_tx;
            tick(v, r, t, acc);
            if (acc) void'(pend_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        if (pend_q.size() > 0 || exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rand_drain: %0d inputs and %0d outputs outstanding, required 0",
                     pend_q.size(), exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
